pipe_addsub: RTL and testbench

//  Parametrised, pipelined adder/subtractor; successor to the single-bit half/full-adder cells.

---
 rtl/pipe_addsub_pkg.sv | 24 ++
 rtl/pipe_addsub_chunk.sv | 33 +++
 rtl/pipe_addsub.sv | 126 ++++++++++++
 tb/tb_pipe_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared mode encoding, chunk sizing and full-adder cell
package pipe_addsub_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Bits handled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The word must split evenly into at least one chunk.
  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (width % stages == 0);
  endfunction

  // Single-bit full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// rtl/pipe_addsub_chunk.sv - combinational ripple adder for one pipeline chunk
module addsub_chunk
  import pipe_addsub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic       c;
  logic [1:0] fa_r;

  // Ripple the carry through W full-adder cells; c_msb is the carry into the top bit.
  always_comb begin
    s     = '0;
    c     = ci;
    c_msb = ci;
    fa_r  = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb = c;
      fa_r = full_add(a[i], b[i], c);
      s[i] = fa_r[0];
      c    = fa_r[1];
    end
    co = c;
  end

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/sub with carry registered between chunks
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_width
    $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  // Register k holds the beat after stage k has added chunk k.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic                         ovf_q, ovf_d;

  // What each stage sees on its input side.
  logic [STAGES-1:0]            stg_v, stg_c;
  logic [STAGES-1:0][WIDTH-1:0] stg_a, stg_b, stg_sum;

  logic [STAGES-1:0][CHUNK-1:0] chunk_s;
  logic [STAGES-1:0]            chunk_co, chunk_cmsb;

  logic is_sub;
  logic adv;

  assign is_sub    = (mode_e'(sub) == MODE_SUB);
  assign out_valid = valid_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  // Stage 0 takes the ports (b inverted with carry-in forced for subtract); later stages take the previous register.
  always_comb begin
    stg_v[0]   = in_valid;
    stg_a[0]   = a;
    stg_b[0]   = is_sub ? ~b : b;
    stg_c[0]   = is_sub ? 1'b1 : cin;
    stg_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      stg_v[k]   = valid_q[k-1];
      stg_a[k]   = a_q[k-1];
      stg_b[k]   = b_q[k-1];
      stg_c[k]   = carry_q[k-1];
      stg_sum[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk #(.W(CHUNK)) u_chunk (
      .a     (stg_a[k][k*CHUNK +: CHUNK]),
      .b     (stg_b[k][k*CHUNK +: CHUNK]),
      .ci    (stg_c[k]),
      .s     (chunk_s[k]),
      .co    (chunk_co[k]),
      .c_msb (chunk_cmsb[k])
    );
  end

  // Shift the whole pipe on adv, otherwise hold every register (global stall).
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    if (adv) begin
      valid_d = stg_v;
      carry_d = chunk_co;
      a_d     = stg_a;
      b_d     = stg_b;
      for (int k = 0; k < STAGES; k++) begin
        sum_d[k]                    = stg_sum[k];
        sum_d[k][k*CHUNK +: CHUNK]  = chunk_s[k];
      end
      ovf_d = chunk_co[STAGES-1] ^ chunk_cmsb[STAGES-1];
    end
  end

  // Pipeline registers; reset clears every in-flight beat and the result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

  // Already-consumed operand chunks and lower-stage carry-into-MSB are not needed downstream.
  logic unused_ok;
  assign unused_ok = ^{a_q, b_q, chunk_cmsb};

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - randomized and directed checks of pipe_addsub against a reference model
module tb_pipe_addsub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t dir_exp;
  bit   use_dir  = 0;
  bit   lat_chk  = 0;
  bit   hold_chk = 0;
  logic [31:0] held;
  bit   acc;
  logic last_in_ready;
  int   cyc_n  = 0;
  int   n_emit = 0;
  int   n_acc  = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference: unsigned sum/difference for {cout,sum}, signed range test for ovf.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    exp_t e;
    int   sx, sy, r;
    int   ux, uy, u;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    if (sb) begin
      u   = ux - uy;
      e.c = (ux >= uy);
      r   = sx - sy;
    end else begin
      u   = ux + uy + int'(ci);
      e.c = (u >= 65536);
      r   = sx + sy + int'(ci);
    end
    e.s = 16'(u);
    e.o = (r > 32767) || (r < -32768);
    e.t = 0;
    return e;
  endfunction

  // One clock cycle: entered and left just after a falling edge, with inputs already driven.
  task automatic cyc();
    exp_t e;
    #1;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (hold_chk) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", {14'd0, ovf, cout, sum}, held);
    end
    acc = 0;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("expected_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result", {14'd0, ovf, cout, sum}, {14'd0, e.o, e.c, e.s});
          if (lat_chk) chk("latency", 32'(cyc_n - e.t), 32'(STAGES));
          n_emit++;
        end
      end
      if (in_valid && in_ready) begin
        e   = use_dir ? dir_exp : model(a, b, cin, sub);
        e.t = cyc_n;
        q.push_back(e);
        acc = 1;
        n_acc++;
      end
    end
    hold_chk      = !rst && out_valid && !out_ready;
    held          = {14'd0, ovf, cout, sum};
    last_in_ready = in_ready;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic send_dir(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input logic ts, input logic [15:0] es, input logic ec, input logic eo);
    in_valid  = 1; a = ta; b = tb_; cin = tc; sub = ts; out_ready = 1;
    dir_exp   = '{es, ec, eo, 0};
    use_dir   = 1;
    cyc();
    chk("dir_accept", 32'(acc), 32'd1);
    use_dir  = 0;
    in_valid = 0;
    for (int i = 0; i < 8; i++) cyc();
    chk("dir_drained", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vs [8];

  initial begin
    int idx;
    int emit0;
    rst = 1; in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
    @(negedge clk);
    cyc();
    cyc();

    // Reset state, one cycle after rst drops.
    rst = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", {14'd0, ovf, cout, sum}, 32'd0);
    @(negedge clk);

    // Directed boundary vectors with exact latency.
    lat_chk = 1;
    send_dir(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    send_dir(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    send_dir(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    send_dir(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    send_dir(16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0);
    send_dir(16'h1234, 16'h0FFF, 1, 0, 16'h2234, 0, 0);

    // Eight back-to-back beats with out_ready low in cycles 5..7.
    lat_chk = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vs[i] = 1'($urandom);
    end
    idx   = 0;
    emit0 = n_emit;
    for (int c = 1; c <= 30; c++) begin
      in_valid  = (idx < 8);
      a         = va[idx % 8];
      b         = vb[idx % 8];
      sub       = vs[idx % 8];
      cin       = 1'($urandom);
      out_ready = !(c >= 5 && c <= 7);
      cyc();
      if (c >= 5 && c <= 7) chk("stall_in_ready", 32'(last_in_ready), 32'd0);
      if (acc) idx++;
    end
    chk("burst_accepted", 32'(idx), 32'd8);
    chk("burst_emitted", 32'(n_emit - emit0), 32'd8);

    // Three beats in flight, then a one-cycle reset: none may come out afterwards.
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      cyc();
    end
    in_valid = 0;
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    emit0 = n_emit;
    for (int i = 0; i < 10; i++) cyc();
    chk("midrst_no_stale", 32'(n_emit - emit0), 32'd0);

    // Random traffic with random back-pressure.
    emit0 = n_emit;
    idx   = n_acc;
    for (int c = 0; c < 40000 && (n_acc - idx) < 10000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      cyc();
    end
    in_valid  = 0;
    out_ready = 1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cyc();
    chk("random_accepted", 32'(n_acc - idx), 32'd10000);
    chk("random_emitted", 32'(n_emit - emit0), 32'd10000);
    chk("random_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
